// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg -- shared types and constants for the SRAM port arbiter.
//   state_t : controller state (ST_INIT zero-fill, ST_RUN normal arbitration)
//   req_t   : one requester's request bundle (valid, write, addr, wdata)
// The macro geometry constants describe the 12288x32 single-port macro.
package sram_arb_pkg;

    localparam int SRAM_ADDR_W = 14;
    localparam int SRAM_DATA_W = 32;
    localparam int SRAM_DEPTH  = 12288;
    localparam int STARVE_W    = 4;     // holds STARVE_MAX values 1..15

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic                   valid;
        logic                   write;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/sram_arb_grant.sv
// sram_arb_grant -- two-port priority arbiter with starvation protection.
//   clock, reset (async, active-low)
//   run         : arbitration enabled (low during reset and zero-fill)
//   req0_valid  : port 0 request (normal priority winner)
//   req1_valid  : port 1 request
//   grant[1:0]  : one-hot grant, bit N = port N, all zero when nobody wins
// Port 1 is forced through once it has been refused STARVE_MAX cycles in a row.
module sram_arb_grant
    import sram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic [1:0] grant
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt_reg;
    logic [STARVE_W-1:0] starve_cnt_next;
    logic                force1;

    always_comb begin
        force1 = (starve_cnt_reg == STARVE_LIM) && req1_valid;
        grant  = 2'b00;
        if (run) begin
            if (req1_valid && (force1 || !req0_valid)) begin
                grant = 2'b10;
            end else if (req0_valid) begin
                grant = 2'b01;
            end
        end
    end

    // Counts consecutive refused cycles; any gap in port 1 demand forgets history.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!run || !req1_valid || grant[1]) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != STARVE_LIM) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter -- controller/arbiter in front of one single-port SRAM macro.
//   clock, reset        : rising-edge clock, async active-low reset
//   req0_* / resp0_*    : port 0 (core, priority) request handshake and read response
//   req1_* / resp1_*    : port 1 (DMA/maintenance) request handshake and read response
//   sram_en/wmode/addr/wdata/rdata : RW0-style macro interface, rdata one cycle after read
//   init_busy           : high while the post-reset zero-fill runs
// Optional macro SRAM_ARB_INIT_EN: adds the INIT state that zero-fills all DEPTH
// entries after reset before any request is accepted.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = SRAM_ADDR_W,
    parameter int DATA_W     = SRAM_DATA_W,
    parameter int DEPTH      = SRAM_DEPTH,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_rdata,
    output logic              resp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,
    output logic              resp1_err,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              init_busy
);

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    req_t              req [2];
    state_t            state;
    logic [ADDR_W-1:0] init_addr;
    logic              run;
    logic              filling;
    logic [1:0]        grant;
    logic              any_grant;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_range;

    logic              rsp_valid_reg;
    logic              rsp_port_reg;
    logic              rsp_err_reg;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_err;
    logic [DATA_W-1:0] resp_rdata [2];

    assign req[0] = '{valid: req0_valid, write: req0_write, addr: req0_addr, wdata: req0_wdata};
    assign req[1] = '{valid: req1_valid, write: req1_write, addr: req1_addr, wdata: req1_wdata};

`ifdef SRAM_ARB_INIT_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] init_cnt_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_INIT;
            init_cnt_reg <= '0;
        end else if (state == ST_INIT) begin
            if (init_cnt_reg == LAST_ADDR) begin
                state        <= ST_RUN;
                init_cnt_reg <= '0;
            end else begin
                init_cnt_reg <= init_cnt_reg + 1'b1;
            end
        end
    end

    assign init_addr = init_cnt_reg;
`else
    assign state     = ST_RUN;
    assign init_addr = '0;
`endif

    // Reset is folded in so nothing is granted or driven while it is held.
    assign run       = reset && (state == ST_RUN);
    assign filling   = reset && (state == ST_INIT);
    assign init_busy = (state == ST_INIT);

    sram_arb_grant #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .req0_valid (req[0].valid),
        .req1_valid (req[1].valid),
        .grant      (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign any_grant  = |grant;
    assign sel_write  = grant[1] ? req[1].write : req[0].write;
    assign sel_addr   = grant[1] ? req[1].addr  : req[0].addr;
    assign sel_wdata  = grant[1] ? req[1].wdata : req[0].wdata;
    assign in_range   = ({1'b0, sel_addr} < DEPTH_V);

    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (filling) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = init_addr;
        end else if (any_grant) begin
            // Out-of-range accesses are accepted but never reach the macro.
            sram_en    = in_range;
            sram_wmode = sel_write;
            sram_addr  = sel_addr;
            sram_wdata = sel_wdata;
        end
    end

    // One-deep response tag aligned with the macro's one-cycle read latency.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_valid_reg <= 1'b0;
            rsp_port_reg  <= 1'b0;
            rsp_err_reg   <= 1'b0;
        end else begin
            rsp_valid_reg <= any_grant && !sel_write;
            rsp_port_reg  <= grant[1];
            rsp_err_reg   <= !in_range;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            assign resp_valid[gi] = rsp_valid_reg && (rsp_port_reg == 1'(gi));
            assign resp_err[gi]   = resp_valid[gi] && rsp_err_reg;
            assign resp_rdata[gi] = (resp_valid[gi] && !rsp_err_reg) ? sram_rdata : '0;
        end
    endgenerate

    assign resp0_valid = resp_valid[0];
    assign resp0_err   = resp_err[0];
    assign resp0_rdata = resp_rdata[0];
    assign resp1_valid = resp_valid[1];
    assign resp1_err   = resp_err[1];
    assign resp1_rdata = resp_rdata[1];

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Controller and arbiter in front of one single-port 12288x32 SRAM macro.
- The macro has a RW0-style interface: en, wmode, 14-bit addr, 32-bit wdata, and rdata valid one cycle after a read.
- Shares the macro between two requesters: port 0 (core, priority) and port 1 (DMA/maintenance) with starvation protection.
- Sequences an optional post-reset zero-fill and returns read responses with fixed latency.

Parameters:
- ADDR_W, 14, address width.
- DATA_W, 32, data width.
- DEPTH, 12288, number of valid entries; addresses >= DEPTH are out of range.
- STARVE_MAX, 4, consecutive denied cycles of port 1 before it gets forced priority (range 1..15).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  port 0 request.
- req0_ready  out  1  port 0 accept; handshake completes when valid && ready.
- req0_write  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  port 0 address.
- req0_wdata  in  DATA_W  port 0 write data.
- resp0_valid  out  1  port 0 read data valid.
- resp0_rdata  out  DATA_W  port 0 read data; 0 when resp0_valid is low.
- resp0_err  out  1  port 0 out-of-range flag, qualified by resp0_valid.
- req1_* / resp1_*: same set as port 0, for port 1.
- sram_en  out  1  to macro RW0_en.
- sram_wmode  out  1  to macro RW0_wmode.
- sram_addr  out  ADDR_W  to macro RW0_addr.
- sram_wdata  out  DATA_W  to macro RW0_wdata.
- sram_rdata  in  DATA_W  from macro RW0_rdata.
- init_busy  out  1  high while the zero-fill runs.

Behaviour:
- Reset values: all ready/resp_valid/resp_err low, resp_rdata 0, sram_en 0, starvation counter 0, init counter 0. init_busy is 1 with SRAM_ARB_INIT_EN, else 0.
- States: INIT, RUN. Reset enters INIT if SRAM_ARB_INIT_EN is defined, else RUN.
- INIT:
  - Both ready outputs low.
  - Each cycle: sram_en=1, wmode=1, addr=init_cnt, wdata=0.
  - init_cnt counts 0..DEPTH-1, then the block moves to RUN on the next edge.
  - Takes exactly DEPTH cycles.
  - init_busy drops in the first RUN cycle.
- RUN arbitration, combinational within the cycle:
  - Default grant goes to port 0 if req0_valid, else port 1.
  - If starve_cnt == STARVE_MAX and req1_valid, port 1 is granted regardless of port 0.
  - Only the granted port sees ready=1. At most one access per cycle.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each cycle req1_valid=1 and port 1 is not granted.
  - Clears on a port-1 grant or when req1_valid=0.
- Access drive: on a grant, sram_en=1, wmode=reqX_write, addr/wdata from the granted port. With no grant, sram_en=0.
- Out-of-range (addr >= DEPTH):
  - The request is still accepted, but sram_en is forced to 0.
  - A write is dropped.
  - A read returns resp_valid with rdata=0 and resp_err=1 one cycle later.
- Read latency: a read accepted on edge N gets respX_valid=1 during cycle N+1, with respX_rdata = sram_rdata. Responses have no backpressure; the requester must sink them.
- Writes produce no response.
- Read-after-write: a write accepted on edge N followed by a read of the same address on edge N+1 returns the new data at N+2.
- Reset asserted mid-operation:
  - In-flight responses are discarded (resp_valid=0 immediately).
  - The FSM returns to INIT and restarts the zero-fill from address 0.

Optional Feature:
- SRAM_ARB_INIT_EN defined: INIT state and zero-fill present; ports stall for DEPTH cycles after reset.
- Not defined: no init counter; reset goes straight to RUN; init_busy tied 0; memory contents undefined until written.

Decomposition:
- Package sram_arb_pkg holds: state enum {INIT, RUN}, the DEPTH/ADDR_W/DATA_W constants, and the request struct (valid, write, addr, wdata).
- One natural sub-module: sram_arb_grant. It holds the combinational priority plus the starvation counter and outputs a one-hot grant.
- The top handles the FSM, the SRAM drive and the response pipeline register (valid, port id, err).

Test Plan:
- Zero-fill, macro defined: release reset, hold req0_valid=1 -> req0_ready=0 for 12288 cycles, sram_wdata=0 at each addr 0..12287, init_busy falls; then read addr 0x1ABC -> resp0_rdata=0.
- Write/read: port 0 writes 0xDEADBEEF to addr 0x0010, then reads addr 0x0010 next cycle -> resp0_valid exactly 1 cycle after accept, rdata=0xDEADBEEF, resp1_valid stays 0.
- Starvation: req0_valid and req1_valid held high continuously -> port 0 granted 4 cycles, port 1 granted on the 5th, pattern repeats every 5 cycles.
- Out-of-range: port 1 reads addr 12288 -> sram_en=0, resp1_valid=1, resp1_err=1, rdata=0; a write to 0x3FFF leaves all memory unchanged.
- Mid-op reset: assert reset the cycle after a read is accepted -> resp_valid stays 0; after release init_busy=1 and the fill restarts at address 0.
- Macro undefined: ready high on the first cycle after reset release; back-to-back port 1 reads of addrs 5,6,7 -> three consecutive resp1_valid cycles, in order.
